frame_sequencer: RTL and testbench

- Upstream stage of the matrix output stage (SPI data + column-select shift register).
- Walks one frame from a synchronous frame-buffer RAM, column by column and word by word.
- Drives the output stage's command pulses (new_image / new_column / next_data) and holds data stable while each transfer runs.
- Uses the output stage's tx_finish level as its only flow control.

---
 rtl/frame_sequencer.sv | 171 +++++++++++++++++
 tb/tb_frame_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: walks one frame of a synchronous frame-buffer RAM column by column,
//   word by word, and drives command pulses into the SPI/column-select output stage.
// Latency: accept -> RAM read 1 cycle, -> command 3 cycles; 5 cycles of overhead per transfer.
// Backpressure: the output stage's tx_finish level is the only flow control; the
//   sequencer parks in ISSUE/WAIT_BUSY/WAIT_DONE for as long as the output stage needs.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   frame_start       one-cycle frame request (1-deep pending while busy)
//   frame_extra_bit   extra_bit for the frame, sampled when the request is accepted
//   rd_en / rd_addr   RAM read strobe and word address (col*WORDS_PER_COLUMN + word)
//   rd_data           RAM data one cycle after rd_en, lane c at [c*SPI_SIZE +: SPI_SIZE]
//   data_out          per-lane data held stable for the output stage
//   new_image / new_column / next_data   mutually exclusive one-cycle command pulses
//   extra_bit         latched frame_extra_bit
//   tx_finish         output stage idle level (1 = idle)
//   busy, frame_done  frame in progress / one-cycle end-of-frame pulse
//   error             one-cycle watchdog abort pulse
//
// Optional: define FRAME_SEQUENCER_WATCHDOG_EN to abort a frame when the output stage
//   stays in one wait state for TIMEOUT_CYCLES cycles. Without it, error is tied 0.
module frame_sequencer #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int COLUMNS          = 16,
  parameter int WORDS_PER_COLUMN = 8,
  parameter int ADDR_WIDTH       = 7,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               frame_start,
  input  logic                               frame_extra_bit,
  output logic                               rd_en,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data,
  output logic [SPI_SIZE-1:0]                data_out [CHANNEL_NUMBER],
  output logic                               new_image,
  output logic                               new_column,
  output logic                               next_data,
  output logic                               extra_bit,
  input  logic                               tx_finish,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               error
);

  localparam int COL_W  = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int WORD_W = (WORDS_PER_COLUMN > 1) ? $clog2(WORDS_PER_COLUMN) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] LATCH     = 3'd2;
  localparam logic [2:0] ISSUE     = 3'd3;
  localparam logic [2:0] WAIT_BUSY = 3'd4;
  localparam logic [2:0] WAIT_DONE = 3'd5;
  localparam logic [2:0] ADVANCE   = 3'd6;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [COL_W-1:0]    r_col;
  logic [WORD_W-1:0]   r_word;
  logic                r_pending;
  logic                r_extra;
  logic [SPI_SIZE-1:0] r_data_out [CHANNEL_NUMBER];

  logic w_accept;
  logic w_last_word;
  logic w_last_col;
  logic w_issue;
  logic w_timeout;

  assign w_last_word = (r_word == WORD_W'(WORDS_PER_COLUMN - 1));
  assign w_last_col  = (r_col == COL_W'(COLUMNS - 1));
  assign w_accept    = (r_state == IDLE) && (frame_start || r_pending);
  // The command fires in the same cycle ISSUE sees the output stage idle.
  assign w_issue     = (r_state == ISSUE) && tx_finish;

`ifdef FRAME_SEQUENCER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_waiting;

  assign w_waiting = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
  assign w_timeout = w_waiting && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES));

  // Counts cycles spent in the current wait state; any state change restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (w_waiting && (w_state_nxt == r_state)) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end else begin
      r_wd_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_state_nxt = FETCH;
      FETCH:     w_state_nxt = LATCH;
      LATCH:     w_state_nxt = ISSUE;
      ISSUE:     if (tx_finish) w_state_nxt = WAIT_BUSY;
      // tx_finish dropping is the output stage acknowledging the command.
      WAIT_BUSY: if (!tx_finish) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_finish) w_state_nxt = ADVANCE;
      ADVANCE:   w_state_nxt = (w_last_word && w_last_col) ? IDLE : FETCH;
      default:   w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_word    <= '0;
      r_pending <= 1'b0;
      r_extra   <= 1'b0;
      for (int c = 0; c < CHANNEL_NUMBER; c++) r_data_out[c] <= '0;
    end else begin
      r_state <= w_state_nxt;

      // Pending request: consumed (or dropped as a duplicate) in IDLE, armed while busy,
      // discarded by a watchdog abort.
      if (r_state == IDLE || w_timeout) begin
        r_pending <= 1'b0;
      end else if (frame_start) begin
        r_pending <= 1'b1;
      end

      if (w_accept) begin
        r_extra <= frame_extra_bit;
        r_col   <= '0;
        r_word  <= '0;
      end

      if (r_state == LATCH) begin
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
          r_data_out[c] <= rd_data[c*SPI_SIZE +: SPI_SIZE];
        end
      end

      if (r_state == ADVANCE && !(w_last_word && w_last_col)) begin
        if (!w_last_word) begin
          r_word <= r_word + WORD_W'(1);
        end else begin
          r_word <= '0;
          r_col  <= r_col + COL_W'(1);
        end
      end
    end
  end

  assign rd_en      = (r_state == FETCH);
  assign rd_addr    = rd_en ? (ADDR_WIDTH'(r_col) * ADDR_WIDTH'(WORDS_PER_COLUMN) + ADDR_WIDTH'(r_word))
                            : '0;
  assign new_image  = w_issue && (r_word == '0) && (r_col == '0);
  assign new_column = w_issue && (r_word == '0) && (r_col != '0);
  assign next_data  = w_issue && (r_word != '0);
  assign extra_bit  = r_extra;
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == ADVANCE) && w_last_word && w_last_col;
  assign error      = w_timeout;
  assign data_out   = r_data_out;

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  localparam int CH   = 3;
  localparam int SZ   = 8;
  localparam int COLS = 16;
  localparam int WPC  = 8;
  localparam int AW   = 7;
  localparam int TO   = 64;
  localparam int NX   = COLS * WPC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic frame_extra_bit = 1'b0;
  logic tx_finish = 1'b1;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic [CH*SZ-1:0] rd_data = '0;
  logic [SZ-1:0] data_out [CH];
  logic new_image, new_column, next_data, extra_bit, busy, frame_done, error;

  always #5 clk = ~clk;

  frame_sequencer #(
    .CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .COLUMNS(COLS), .WORDS_PER_COLUMN(WPC),
    .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_extra_bit(frame_extra_bit),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .data_out(data_out),
    .new_image(new_image), .new_column(new_column), .next_data(next_data),
    .extra_bit(extra_bit), .tx_finish(tx_finish), .busy(busy),
    .frame_done(frame_done), .error(error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Tallies of observed DUT activity and output-stage model controls.
  int n_img = 0, n_col = 0, n_nxt = 0, n_rd = 0, n_done = 0, n_err = 0;
  int xfer_len = 20;
  bit never_ack = 1'b0;
  int low_left = 0;

  // Reference model: timestamps of the next expected read / command window / advance.
  int cyc = 0;
  int m_idx = 0, m_read_at = -1, m_cmd_from = -1, m_lat_at = -1, m_adv_at = -1;
  int m_stage = 0;  // 0 none, 1 command owed, 2 awaiting ack, 3 awaiting completion
  int m_wd = 0;
  bit m_busy = 1'b0, m_pend = 1'b0, m_extra = 1'b0;
  logic [7:0] m_data = '0;

  initial begin : monitor
    bit e_rd, e_cmd, e_last, e_done, e_err, cur_busy, tx_next;
    logic [CH*SZ-1:0] rd_next;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc == m_cmd_from) m_stage = 1;
      e_rd   = (cyc == m_read_at);
      e_cmd  = (m_stage == 1) && tx_finish;
      e_last = (m_idx == NX - 1);
      e_done = (cyc == m_adv_at) && e_last;
      e_err  = 1'b0;
`ifdef FRAME_SEQUENCER_WATCHDOG_EN
      e_err  = (m_stage >= 2) && (m_wd == TO);
`endif
      chk("rd_en", rd_en, e_rd);
      if (e_rd) chk("rd_addr", rd_addr, m_idx);
      chk("new_image", new_image, e_cmd && m_idx == 0);
      chk("new_column", new_column, e_cmd && m_idx != 0 && (m_idx % WPC) == 0);
      chk("next_data", next_data, e_cmd && (m_idx % WPC) != 0);
      chk("frame_done", frame_done, e_done);
      chk("busy", busy, m_busy);
      chk("error", error, e_err);
      chk("extra_bit", extra_bit, m_extra);
      for (int k = 0; k < CH; k++) chk("data_out", data_out[k], m_data);

      if (new_image) n_img++;
      if (new_column) n_col++;
      if (next_data) n_nxt++;
      if (rd_en) n_rd++;
      if (frame_done) n_done++;
      if (error) n_err++;

      // Output stage: busy (tx_finish low) for xfer_len cycles after each command.
      if ((new_image || new_column || next_data) && !never_ack) low_left = xfer_len;
      tx_next = (low_left == 0);
      if (low_left > 0) low_left--;
      // Frame buffer: RAM[a] = a on every lane.
      rd_next = rd_en ? {CH{{1'b0, rd_addr}}} : rd_data;

      if (rst) begin
        m_busy = 0; m_pend = 0; m_extra = 0; m_data = '0; m_stage = 0; m_idx = 0;
        m_read_at = -1; m_cmd_from = -1; m_lat_at = -1; m_adv_at = -1; m_wd = 0;
      end else begin
        cur_busy = m_busy;
        if (cyc == m_lat_at) m_data = 8'(m_idx);
        if (e_err) begin
          m_stage = 0; m_busy = 0; m_pend = 0; m_adv_at = -1;
        end else begin
          case (m_stage)
            1: if (tx_finish) begin m_stage = 2; m_wd = 0; end
            2: if (!tx_finish) begin m_stage = 3; m_wd = 0; end else m_wd++;
            3: if (tx_finish) begin m_stage = 0; m_adv_at = cyc + 1; end else m_wd++;
            default: ;
          endcase
          if (e_rd) begin m_lat_at = cyc + 1; m_cmd_from = cyc + 2; end
          if (cyc == m_adv_at) begin
            if (e_last) m_busy = 0;
            else begin m_idx++; m_read_at = cyc + 1; end
          end
          if (cur_busy && frame_start) m_pend = 1;
        end
        if (!cur_busy && (frame_start || m_pend)) begin
          m_busy = 1; m_pend = 0; m_extra = frame_extra_bit; m_idx = 0; m_read_at = cyc + 1;
        end
      end

      @(posedge clk);
      #1;
      tx_finish = tx_next;
      rd_data = rd_next;
    end
  end

  task automatic pulse_start(input logic eb);
    @(posedge clk); #1;
    frame_start = 1'b1; frame_extra_bit = eb;
    @(posedge clk); #1;
    frame_start = 1'b0; frame_extra_bit = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (frame_done) begin got = 1'b1; break; end
    end
    chk(nm, got, 1);
  endtask

  task automatic wait_column(input int n, input string nm);
    int seen = 0;
    for (int i = 0; i < 4000 && seen < n; i++) begin
      @(negedge clk);
      if (new_column) seen++;
    end
    chk(nm, seen, n);
  endtask

  initial begin : stimulus
    int b_img, b_col, b_nxt, b_rd, viol;
    bit stable, got;
    logic [SZ-1:0] snap [CH];

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset rd_en", rd_en, 0);
    chk("reset cmds", {new_image, new_column, next_data}, 0);
    chk("reset data_out", data_out[0], 0);

    // Frame 1 with extra_bit=1; a second request (extra 0) pends, a third is dropped.
    b_img = n_img; b_col = n_col; b_nxt = n_nxt; b_rd = n_rd;
    pulse_start(1'b1);
    @(negedge clk);
    chk("f1 first rd_en", rd_en, 1);
    chk("f1 first rd_addr", rd_addr, 0);
    chk("f1 busy", busy, 1);
    chk("f1 extra_bit", extra_bit, 1);
    repeat (40) @(negedge clk);
    pulse_start(1'b0);
    repeat (30) @(negedge clk);
    pulse_start(1'b1);

    // col 3, word 0 -> address 24
    wait_column(3, "f1 reach col3");
    for (int k = 0; k < CH; k++) chk("col3 data_out", data_out[k], 24);
    snap = data_out;
    stable = 1'b1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (data_out != snap) stable = 1'b0;
      if (tx_finish) begin got = 1'b1; break; end
    end
    chk("col3 data stable", stable, 1);
    chk("col3 transfer ends", got, 1);

    wait_done("f1 done");
    chk("f1 new_image count", n_img - b_img, 1);
    chk("f1 new_column count", n_col - b_col, 15);
    chk("f1 next_data count", n_nxt - b_nxt, 112);
    chk("f1 read count", n_rd - b_rd, 128);
    chk("f1 extra at done", extra_bit, 1);

    // Pending request launches frame 2 right after frame_done, with extra_bit=0.
    @(negedge clk);
    chk("f2 idle gap busy", busy, 0);
    b_img = n_img; b_col = n_col; b_nxt = n_nxt; b_rd = n_rd;
    @(negedge clk);
    chk("f2 first rd_en", rd_en, 1);
    chk("f2 first rd_addr", rd_addr, 0);
    chk("f2 extra_bit", extra_bit, 0);

    // Stall: one transfer keeps tx_finish low for 50 cycles.
    repeat (100) @(negedge clk);
    @(posedge clk); #1 xfer_len = 50;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (new_image || new_column || next_data) begin got = 1'b1; break; end
    end
    chk("stall cmd seen", got, 1);
    @(posedge clk); #1 xfer_len = 20;
    viol = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_finish) begin got = 1'b1; break; end
      if (rd_en || new_image || new_column || next_data) viol++;
    end
    chk("stall no activity", viol, 0);
    chk("stall released", got, 1);
    @(negedge clk);
    chk("stall advance no read", rd_en, 0);
    @(negedge clk);
    chk("stall next read", rd_en, 1);

    wait_done("f2 done");
    chk("f2 new_image count", n_img - b_img, 1);
    chk("f2 new_column count", n_col - b_col, 15);
    chk("f2 next_data count", n_nxt - b_nxt, 112);
    chk("f2 read count", n_rd - b_rd, 128);
    repeat (20) @(negedge clk);
    chk("third request dropped busy", busy, 0);
    chk("frames done after f2", n_done, 2);

    // Frame 3: reset at column 5, then restart from address 0.
    pulse_start(1'b1);
    wait_column(5, "f3 reach col5");
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst rd_en", rd_en, 0);
    chk("rst cmds", {new_image, new_column, next_data}, 0);
    chk("rst extra_bit", extra_bit, 0);
    chk("rst frame_done", frame_done, 0);
    for (int k = 0; k < CH; k++) chk("rst data_out", data_out[k], 0);
    repeat (5) @(negedge clk);
    chk("rst no frame_done", n_done, 2);
    pulse_start(1'b0);
    @(negedge clk);
    chk("restart rd_en", rd_en, 1);
    chk("restart rd_addr", rd_addr, 0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (new_image || new_column || next_data) begin got = 1'b1; break; end
    end
    chk("restart cmd seen", got, 1);
    chk("restart new_image", new_image, 1);
    wait_done("f3 done");
    repeat (3) @(negedge clk);
    chk("frames done after f3", n_done, 3);

`ifdef FRAME_SEQUENCER_WATCHDOG_EN
    begin : watchdog
      int t = 0, t_cmd = -1, t_err = -1;
      never_ack = 1'b1;
      pulse_start(1'b0);
      for (int i = 0; i < 400 && t_err < 0; i++) begin
        @(negedge clk);
        t++;
        if (new_image && t_cmd < 0) t_cmd = t;
        if (error) t_err = t;
      end
      chk("wd error seen", t_err >= 0, 1);
      chk("wd error delay", t_err - t_cmd, TO + 1);
      @(negedge clk);
      chk("wd busy cleared", busy, 0);
      chk("wd no frame_done", n_done, 3);
      never_ack = 1'b0;
    end
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
